// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a uart_tx: launches one byte at a time with a
// single-cycle tx_en pulse, then waits for the transmitter to go idle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          ovf_clr,
  input  logic          tx_busy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [7:0]    last_reg;
  logic          ovf_reg;
  logic          push;
  logic          pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign overflow = ovf_reg;

  // Full/empty come from start-of-cycle state, so a pop never frees a slot
  // for a write in the same cycle; flush suppresses both push and launch.
  assign push = wr_en & ~full & ~flush;
  assign pop  = (state_reg == IDLE) & ~empty & ~tx_busy & ~flush;

  // The head byte is shown directly during the launch cycle so that a write
  // into an empty FIFO starts transmitting on the very next cycle.
  assign tx_en   = pop;
  assign tx_data = pop ? mem[head_reg] : last_reg;

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // ARM covers the cycle before uart_tx can raise busy after tx_en.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pop) state_next = ARM;
      ARM:     state_next = WAIT;
      WAIT:    if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      last_reg  <= 8'h00;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (flush) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + AW'(1);
        if (pop)  head_reg <= head_reg + AW'(1);
      end
      if (pop) last_reg <= mem[head_reg];
      if (wr_en && full && !flush) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // Storage is never reset; entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail_reg] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          ovf_clr;
  logic          tx_busy;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .tx_busy  (tx_busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: queued bytes, sticky flag, last launched byte, and the
  // launch gap rule (after a launch, uart busy must be seen low at least two
  // cycles later before the next launch may start).
  logic [7:0] q[$];
  logic [7:0] seen[$];
  bit         m_ovf;
  logic [7:0] m_last;
  bit         m_waiting;
  int         m_since;
  int         busy_left;
  int         busy_len;
  bit         busy_forced;
  bit         busy_force_val;
  bit         rand_busy;

  task automatic model_reset();
    q.delete();
    m_ovf     = 1'b0;
    m_last    = 8'h00;
    m_waiting = 1'b0;
    m_since   = 1000;
    busy_left = 0;
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit f, input bit oc);
    bit         m_full;
    bit         m_empty;
    bit         m_launch;
    logic [7:0] exp_data;
    wr_en   = w;
    wr_data = d;
    flush   = f;
    ovf_clr = oc;
    if (busy_forced) tx_busy = busy_force_val;
    else tx_busy = (busy_left > 0) || (rand_busy && $urandom_range(0, 9) == 0);
    @(negedge clk);
    m_full   = (q.size() == DEPTH);
    m_empty  = (q.size() == 0);
    m_launch = !m_empty && !f && !tx_busy && !m_waiting;
    exp_data = m_last;
    if (m_launch) exp_data = q[0];
    check("count", int'(count), q.size());
    check("full", int'(full), int'(m_full));
    check("empty", int'(empty), int'(m_empty));
    check("overflow", int'(overflow), int'(m_ovf));
    check("tx_en", int'(tx_en), int'(m_launch));
    check("tx_data", int'(tx_data), int'(exp_data));
    if (tx_en === 1'b1) begin
      seen.push_back(tx_data);
      $display("[TB] t=%0t launch byte 0x%02h", $time, tx_data);
    end
    if (m_waiting && m_since >= 2 && !tx_busy) m_waiting = 1'b0;
    if (busy_left > 0) busy_left--;
    if (m_launch) begin
      m_last = q[0];
      void'(q.pop_front());
      m_waiting = 1'b1;
      m_since   = 1;
      busy_left = (busy_len > 0) ? busy_len : int'($urandom_range(1, 4));
    end else if (m_since < 1000) begin
      m_since++;
    end
    if (f) q.delete();
    else if (w && !m_full) q.push_back(d);
    if (w && m_full && !f) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    ovf_clr = 1'b0;
    tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() > 0 || m_waiting) && n < 500) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check({name, ".drain_timeout"}, int'(n < 500), 1);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         fl;
    bit         oc;
    bit         busy;
    bit         e_txen;
    logic [7:0] e_data;
    int         e_count;
    bit         e_full;
    bit         e_empty;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nxt;

    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 0, 1'b0, 1'b1, 1'b0};

    busy_forced    = 1'b0;
    busy_force_val = 1'b0;
    rand_busy      = 1'b0;
    busy_len       = 3;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;

    // Reset state, observed while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", int'(count), 0);
    check("rst.empty", int'(empty), 1);
    check("rst.full", int'(full), 0);
    check("rst.overflow", int'(overflow), 0);
    check("rst.tx_en", int'(tx_en), 0);
    check("rst.tx_data", int'(tx_data), 0);
    rst_n = 1'b1;

    // Directed vectors: single byte, push+pop in the launch cycle, flush vs write.
    for (int i = 0; i < 16; i++) begin
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].d;
      flush   = tbl[i].fl;
      ovf_clr = tbl[i].oc;
      tx_busy = tbl[i].busy;
      @(negedge clk);
      check($sformatf("vec%0d.tx_en", i), int'(tx_en), int'(tbl[i].e_txen));
      check($sformatf("vec%0d.tx_data", i), int'(tx_data), int'(tbl[i].e_data));
      check($sformatf("vec%0d.count", i), int'(count), tbl[i].e_count);
      check($sformatf("vec%0d.full", i), int'(full), int'(tbl[i].e_full));
      check($sformatf("vec%0d.empty", i), int'(empty), int'(tbl[i].e_empty));
      check($sformatf("vec%0d.overflow", i), int'(overflow), int'(tbl[i].e_ovf));
      $display("[TB] vec%0d wr=%0d d=0x%02h flush=%0d busy=%0d -> tx_en=%0d tx_data=0x%02h count=%0d",
               i, tbl[i].wr, tbl[i].d, tbl[i].fl, tbl[i].busy, tx_en, tx_data, count);
      @(posedge clk);
      #1;
    end

    // Fill to full with the transmitter busy, then overflow and drain.
    do_reset();
    busy_forced    = 1'b1;
    busy_force_val = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", int'(full), 1);
    check("fill.count", int'(count), DEPTH);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("fill.ovf_set", int'(overflow), 1);
    check("fill.count_after_drop", int'(count), DEPTH);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    check("fill.ovf_set_wins", int'(overflow), 1);
    busy_forced = 1'b0;
    busy_len    = 3;
    seen.delete();
    drain("fill");
    check("fill.sent_count", seen.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < seen.size(); i++) begin
      check($sformatf("fill.sent[%0d]", i), int'(seen[i]), i);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("fill.ovf_clr", int'(overflow), 0);

    // Asynchronous reset between edges with five bytes queued and overflow set.
    busy_forced    = 1'b1;
    busy_force_val = 1'b1;
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("arst.count_before", int'(count), 5);
    check("arst.ovf_before", int'(overflow), 1);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.count", int'(count), 0);
    check("arst.tx_en", int'(tx_en), 0);
    check("arst.overflow", int'(overflow), 0);
    check("arst.empty", int'(empty), 1);
    check("arst.tx_data", int'(tx_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    busy_forced = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush while waiting on the transmitter: in-flight byte finishes, rest dropped.
    busy_len = 5;
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    check("flush.count_before", int'(count), 3);
    seen.delete();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush.count_after", int'(count), 0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush.no_more_tx", seen.size(), 0);
    step(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush.resume_count", seen.size(), 1);
    if (seen.size() > 0) check("flush.resume_byte", int'(seen[0]), 8'hD5);
    drain("flush");

    // Wrap-around: 20 bytes streamed through an 8-deep FIFO, 10-cycle uart.
    busy_len = 10;
    seen.delete();
    nxt = 0;
    n   = 0;
    while ((nxt < 20 || q.size() > 0 || m_waiting) && n < 2000) begin
      if (nxt < 20 && q.size() < DEPTH) begin
        step(1'b1, 8'(8'h10 + nxt), 1'b0, 1'b0);
        nxt++;
      end else begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      n++;
    end
    check("wrap.timeout", int'(n < 2000), 1);
    check("wrap.sent_count", seen.size(), 20);
    for (int i = 0; i < 20 && i < seen.size(); i++) begin
      check($sformatf("wrap.sent[%0d]", i), int'(seen[i]), 8'h10 + i);
    end
    check("wrap.overflow", int'(overflow), 0);

    // Randomized traffic with occasional flushes, clears and stray busy.
    busy_len  = 0;
    rand_busy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0);
    end
    rand_busy = 1'b0;
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of byte entries; a power of two, 2..64.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, the width of the occupancy count.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  bus write strobe, one cycle per byte.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port ovf_clr  input  1  clear the sticky overflow flag.
REQ-009 SHALL have port tx_busy  input  1  busy from the downstream uart_tx.
REQ-010 SHALL have port tx_en  output  1  one-cycle start pulse to uart_tx.
REQ-011 SHALL have port tx_data  output  8  byte presented with tx_en.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port count  output  CW  occupied entries, 0..DEPTH.
REQ-015 SHALL have port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-016 SHALL store bytes in a circular buffer with head and tail pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-017 SHALL accept a write when wr_en=1 and full=0, as sampled at the start of the cycle; the byte goes to the tail and the tail advances.
REQ-018 SHALL drop a write when wr_en=1 and full=1, leaving buffer, pointers and count unchanged, and set overflow.
REQ-019 SHALL keep the full decision based on start-of-cycle state: a write while full is dropped even if a pop happens in the same cycle.
REQ-020 SHALL update count as +1 for a push only, -1 for a pop only, and unchanged for a simultaneous push and pop.
REQ-021 SHALL implement a launch FSM with states IDLE, ARM and WAIT.
REQ-022 SHALL, in IDLE with empty=0 and tx_busy=0, assert tx_en for exactly one cycle with tx_data = head byte, pop the head, and go to ARM.
REQ-023 SHALL, in ARM, unconditionally go to WAIT on the next cycle; this covers uart_tx raising busy one cycle after tx_en.
REQ-024 SHALL, in WAIT, return to IDLE in the cycle tx_busy is sampled 0.
REQ-025 SHALL keep tx_en at 0 in ARM and WAIT, so back-to-back bytes are at least 3 cycles apart.
REQ-026 SHALL hold tx_data at the last launched byte between launches.
REQ-027 SHALL give a write into an empty FIFO in IDLE with tx_busy=0 a latency of exactly 1 cycle: tx_en is high in the cycle after wr_en.
REQ-028 SHALL, on flush=1, set head=tail=0 and count=0 on the next edge.
REQ-029 SHALL give flush priority over a same-cycle write (the write is discarded and overflow is not set) and over a same-cycle launch (no tx_en).
REQ-030 SHALL let flush leave the FSM state alone: an ARM/WAIT in progress completes normally, and the in-flight byte is not aborted.
REQ-031 SHALL clear overflow on ovf_clr=1; if a dropped write occurs in the same cycle, set wins.
REQ-032 SHALL drive full, empty and count combinationally from registered state, with no path from wr_en.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force: FSM=IDLE, head=tail=0, count=0, empty=1, full=0, overflow=0, tx_en=0, tx_data=8'h00.
REQ-034 SHALL, on reset mid-transmission, return to IDLE with an empty FIFO; queued bytes are lost and tx_en does not re-pulse.
REQ-035 SHALL leave buffer storage contents unreset; they are never observable while empty=1.
REQ-036 SHALL start operation on the first rising edge after rst_n deasserts, with no extra wait state.

Verification
REQ-037 SHALL be verified by a single byte: tx_busy=0, write 8'h41 -> tx_en=1 with tx_data=8'h41 next cycle, count returns to 0, and empty=1.
REQ-038 SHALL be verified by fill to full: DEPTH=8, tx_busy held 1, write 8'h00..8'h07 -> full=1 and count=8; a 9th write (8'hAA) -> overflow=1 and count stays 8; release busy -> tx_data sequence 00..07 and 8'hAA is never sent.
REQ-039 SHALL be verified by wrap-around: 20 bytes 8'h10..8'h23 streamed, with uart_tx model busy 10 cycles each -> all 20 emitted in order, no loss, and overflow=0.
REQ-040 SHALL be verified by simultaneous push/pop: count=1, IDLE, tx_busy=0, with a write in the same cycle as the launch -> count stays 1 and the written byte launches after WAIT ends.
REQ-041 SHALL be verified by flush during WAIT: 3 bytes queued, flush asserted while WAIT -> count=0 next cycle, the current byte completes, and no further tx_en.
REQ-042 SHALL be verified by async reset mid-run: rst_n pulled low between clock edges with count=5 -> count=0, tx_en=0 and overflow=0 immediately, without waiting for a clock edge.
